// File: rtl/ss_bcd_formatter_pkg.sv
// ss_pkg: shared digit codes, digit count, digit-code type and FSM state encodings for ss_bcd_formatter.
package ss_pkg;
    localparam int NUM_DIGITS = 8;
    localparam logic [4:0] BLANK_CODE = 5'd16;
    localparam logic [4:0] MINUS_CODE = 5'd17;
    typedef logic [4:0] digit_t;
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t CONVERT = 2'd1;
    localparam state_t FORMAT  = 2'd2;
endpackage

// File: rtl/ss_bcd_formatter_dabble.sv
// ss_dabble_step: one double-dabble iteration, add 3 to nibbles >= 5 then shift in the next binary bit.
module ss_dabble_step (
    input  logic [31:0] bcd,
    input  logic        bit_in,
    output logic [31:0] bcd_out
);
    logic [31:0] adj;
    genvar i;
    for (i = 0; i < 8; i++) begin : g_nib
        assign adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    assign bcd_out = (adj << 1) | {31'd0, bit_in};
endmodule

// File: rtl/ss_bcd_formatter.sv
// ss_bcd_formatter: binary to eight held 5-bit digit codes via sequential double dabble, optional leading-zero blanking.
// Define SS_FMT_SIGNED_EN for two's-complement input with a sign digit.
module ss_bcd_formatter
    import ss_pkg::*;
#(
    parameter int             BIN_W      = 27,
    parameter digit_t         BLANK_CODE = ss_pkg::BLANK_CODE,
    parameter digit_t         MINUS_CODE = ss_pkg::MINUS_CODE,
    parameter logic [BIN_W-1:0] MAX_VAL  = BIN_W'(99_999_999)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] in_value,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             blank_en,
    output logic             done,
    output logic             overflow,
    output digit_t           digit0,
    output digit_t           digit1,
    output digit_t           digit2,
    output digit_t           digit3,
    output digit_t           digit4,
    output digit_t           digit5,
    output digit_t           digit6,
    output digit_t           digit7
);
    localparam int CW = $clog2(BIN_W);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);
    state_t state;
    logic [BIN_W-1:0] bin, mag, clamped;
    logic [31:0] bcd, bcd_nxt;
    logic [CW-1:0] cnt;
    logic blank_q, ovf, z;
    logic [NUM_DIGITS-1:0] lz;
    digit_t dig_q [NUM_DIGITS];
    digit_t fmt [NUM_DIGITS];
`ifdef SS_FMT_SIGNED_EN
    localparam logic [BIN_W-1:0] LIM = BIN_W'(9_999_999);
    logic sign_q;
    assign mag = in_value[BIN_W-1] ? -in_value : in_value;
`else
    localparam logic [BIN_W-1:0] LIM = MAX_VAL;
    assign mag = in_value;
`endif
    assign clamped  = (mag > LIM) ? LIM : mag;
    assign in_ready = (state == IDLE) && !reset;

    ss_dabble_step u_step (
        .bcd    (bcd),
        .bit_in (bin[BIN_W-1]),
        .bcd_out(bcd_nxt)
    );

    // lz[i]: digit i and every digit above it are zero; digit0 never qualifies
    always_comb begin
        z  = 1'b1;
        lz = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            z     = z && (bcd[4*i +: 4] == 4'd0);
            lz[i] = z;
        end
        for (int i = 0; i < NUM_DIGITS; i++)
            fmt[i] = (blank_q && lz[i]) ? BLANK_CODE : {1'b0, bcd[4*i +: 4]};
`ifdef SS_FMT_SIGNED_EN
        fmt[NUM_DIGITS-1] = BLANK_CODE;
        for (int i = 1; i < NUM_DIGITS; i++)
            fmt[i] = (sign_q && (blank_q ? (lz[i] && !lz[i-1]) : (i == NUM_DIGITS - 1))) ? MINUS_CODE : fmt[i];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            overflow <= 1'b0;
            ovf      <= 1'b0;
            blank_q  <= 1'b0;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
`ifdef SS_FMT_SIGNED_EN
            sign_q   <= 1'b0;
`endif
            for (int i = 0; i < NUM_DIGITS; i++)
                dig_q[i] <= (i == 0) ? 5'd0 : BLANK_CODE;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    bin     <= clamped;
                    blank_q <= blank_en;
                    ovf     <= mag > LIM;
                    bcd     <= '0;
                    cnt     <= '0;
`ifdef SS_FMT_SIGNED_EN
                    sign_q  <= in_value[BIN_W-1];
`endif
                    state   <= CONVERT;
                end
                CONVERT: begin
                    bcd   <= bcd_nxt;
                    bin   <= bin << 1;
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == LAST) ? FORMAT : CONVERT;
                end
                FORMAT: begin
                    dig_q    <= fmt;
                    done     <= 1'b1;
                    overflow <= ovf;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign digit0 = dig_q[0];
    assign digit1 = dig_q[1];
    assign digit2 = dig_q[2];
    assign digit3 = dig_q[3];
    assign digit4 = dig_q[4];
    assign digit5 = dig_q[5];
    assign digit6 = dig_q[6];
    assign digit7 = dig_q[7];
endmodule

// File: tb/tb_ss_bcd_formatter.sv
// tb_ss_bcd_formatter: directed vector table, random values against a decimal-arithmetic model, busy/reset corner cases.
module tb_ss_bcd_formatter;
    logic clk = 1'b0;
    logic reset, in_valid, blank_en;
    logic [26:0] in_value;
    logic in_ready, done, overflow;
    logic [4:0] digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7;
    logic [39:0] dut_dig, prev;
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [39:0] RST_DIG = {{7{5'd16}}, 5'd0};

    typedef struct {
        logic [26:0] val;
        logic        blank;
        logic [39:0] dig;
        logic        ovf;
    } vec_t;
    vec_t tbl[$];

    ss_bcd_formatter dut (
        .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready),
        .blank_en(blank_en), .done(done), .overflow(overflow),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .digit4(digit4), .digit5(digit5), .digit6(digit6), .digit7(digit7)
    );

    always #5 clk = ~clk;
    assign dut_dig = {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Expected {overflow, digit7..digit0} from decimal arithmetic on the clamped magnitude
    function automatic logic [40:0] model(input logic [26:0] v, input logic b);
        logic [4:0] d [8];
        longint m;
        logic o, neg;
        int msd, top;
        logic [40:0] r;
`ifdef SS_FMT_SIGNED_EN
        neg = v[26];
        m = neg ? (longint'(134217728) - longint'(v)) : longint'(v);
        o = m > 9999999;
        if (o) m = 9999999;
        top = 6;
`else
        neg = 1'b0;
        m = longint'(v);
        o = m > 99999999;
        if (o) m = 99999999;
        top = 7;
`endif
        for (int i = 0; i < 8; i++) begin
            d[i] = 5'(m % 10);
            m = m / 10;
        end
        if (top == 6) d[7] = neg ? 5'd17 : 5'd16;
        if (b) begin
            msd = 0;
            for (int i = 0; i <= top; i++) if (d[i] != 0) msd = i;
            for (int i = msd + 1; i < 8; i++) d[i] = 5'd16;
            if (neg) d[msd+1] = 5'd17;
        end
        r[40] = o;
        for (int i = 0; i < 8; i++) r[5*i +: 5] = d[i];
        return r;
    endfunction

    task automatic start(input logic [26:0] v, input logic b);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_before_start", in_ready, 1);
        in_value = v;
        blank_en = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_value = '0;
        blank_en = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; ev injects a busy in_valid pulse or a reset
    task automatic wait_done(input int ev, input bit ev_rst, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (lat < 60) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (lat == 20 && !ev_rst) chk("digits_hold", dut_dig, prev);
            reset    = ev_rst && ev != 0 && lat == ev;
            in_valid = !ev_rst && ev != 0 && lat == ev;
            in_value = in_valid ? 27'd999 : 27'd0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run(input string nm, input logic [26:0] v, input logic b, input logic [39:0] ed, input logic eo);
        int lat;
        bit got;
        start(v, b);
        wait_done(0, 0, lat, got);
        chk({nm, "_latency"}, lat, 28);
        chk({nm, "_digits"}, dut_dig, ed);
        chk({nm, "_overflow"}, overflow, eo);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_done_pulse"}, done, 0);
        chk({nm, "_ready_after"}, in_ready, 1);
        prev = ed;
    endtask

    initial begin
        logic [40:0] e;
        logic [26:0] v;
        logic b;
        int lat, nd;
        bit got;
        reset = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        blank_en = 1'b0;
        prev = RST_DIG;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_digits", dut_dig, RST_DIG);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);

`ifdef SS_FMT_SIGNED_EN
        tbl.push_back('{-27'd42, 1'b1, {{5{5'd16}}, 5'd17, 5'd4, 5'd2}, 1'b0});
        tbl.push_back('{-27'd42, 1'b0, {5'd17, {5{5'd0}}, 5'd4, 5'd2}, 1'b0});
        tbl.push_back('{27'd42, 1'b1, {{6{5'd16}}, 5'd4, 5'd2}, 1'b0});
        tbl.push_back('{27'h4000000, 1'b0, {5'd17, {7{5'd9}}}, 1'b1});
        tbl.push_back('{27'd9999999, 1'b1, {5'd16, {7{5'd9}}}, 1'b0});
        tbl.push_back('{27'd10000000, 1'b0, {5'd16, {7{5'd9}}}, 1'b1});
        tbl.push_back('{-27'd9999999, 1'b1, {5'd17, {7{5'd9}}}, 1'b0});
        tbl.push_back('{27'd0, 1'b1, {{7{5'd16}}, 5'd0}, 1'b0});
        tbl.push_back('{-27'd5, 1'b0, {5'd17, {6{5'd0}}, 5'd5}, 1'b0});
        tbl.push_back('{-27'd1000, 1'b1, {{3{5'd16}}, 5'd17, 5'd1, 5'd0, 5'd0, 5'd0}, 1'b0});
`else
        tbl.push_back('{27'd12345678, 1'b0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8}, 1'b0});
        tbl.push_back('{27'd405, 1'b1, {{5{5'd16}}, 5'd4, 5'd0, 5'd5}, 1'b0});
        tbl.push_back('{27'd0, 1'b1, {{7{5'd16}}, 5'd0}, 1'b0});
        tbl.push_back('{27'h7FFFFFF, 1'b0, {8{5'd9}}, 1'b1});
        tbl.push_back('{27'd7, 1'b0, {{7{5'd0}}, 5'd7}, 1'b0});
        tbl.push_back('{27'd99999999, 1'b1, {8{5'd9}}, 1'b0});
        tbl.push_back('{27'd100000000, 1'b0, {8{5'd9}}, 1'b1});
        tbl.push_back('{27'd10000000, 1'b1, {5'd1, {7{5'd0}}}, 1'b0});
        tbl.push_back('{27'd0, 1'b0, 40'd0, 1'b0});
        tbl.push_back('{27'd1000, 1'b1, {{4{5'd16}}, 5'd1, 5'd0, 5'd0, 5'd0}, 1'b0});
`endif
        foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i].val, tbl[i].blank, tbl[i].dig, tbl[i].ovf);

        for (int i = 0; i < 100; i++) begin
            case ($urandom_range(0, 3))
                0: v = 27'($urandom_range(0, 999));
                1: v = 27'($urandom_range(99_999_990, 100_000_010));
                2: v = 27'($urandom_range(9_999_990, 10_000_010));
                default: v = 27'($urandom);
            endcase
            b = 1'($urandom_range(0, 1));
            e = model(v, b);
            run($sformatf("rnd%0d", i), v, b, e[39:0], e[40]);
        end

        // busy in_valid pulse must be dropped, not queued
        e = model(27'd555, 1'b0);
        start(27'd555, 1'b0);
        wait_done(10, 0, lat, got);
        chk("busy_got_done", got, 1);
        chk("busy_latency", lat, 28);
        chk("busy_digits", dut_dig, e[39:0]);
        prev = e[39:0];
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) nd++;
        end
        chk("busy_no_queue", nd, 0);
        chk("busy_digits_after", dut_dig, e[39:0]);

        // mid-conversion reset after an overflowing value
        e = model(27'h7FFFFFF, 1'b0);
        run("pre_rst", 27'h7FFFFFF, 1'b0, e[39:0], e[40]);
        start(27'd777, 1'b1);
        wait_done(15, 1, lat, got);
        chk("midrst_no_done", got, 0);
        chk("midrst_digits", dut_dig, RST_DIG);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_ready", in_ready, 1);
        prev = RST_DIG;
        e = model(27'd12345, 1'b1);
        run("post_rst", 27'd12345, 1'b1, e[39:0], e[40]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
